// File: rtl/rename_free_list_ctrl.sv
// Rename controller: owns the physical-register free list, drives RAT remap/overwrite,
// and recovers from flush by restoring the RAT and rescanning every physical tag.
module rename_free_list_ctrl #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned PTAG_W    = $clog2(PHYS_REGS),
    parameter int unsigned AREG_W    = $clog2(ARCH_REGS),
    parameter int unsigned CNT_W     = $clog2(PHYS_REGS - ARCH_REGS) + 1
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_stall,
    input  logic                              i_rn_valid,
    input  logic                              i_rn_has_dest,
    input  logic [AREG_W-1:0]                 i_rn_dest,
    output logic                              o_rn_ready,
    output logic [PTAG_W-1:0]                 o_rn_new_tag,
    output logic [AREG_W-1:0]                 o_rat_reg_to_map,
    output logic [PTAG_W-1:0]                 o_rat_new_mapping,
    output logic                              o_rat_remap,
    input  logic                              i_cm_valid,
    input  logic [PTAG_W-1:0]                 i_cm_free_tag,
    input  logic                              i_flush,
    input  logic [ARCH_REGS-1:0][PTAG_W-1:0]  i_retire_map,
    output logic                              o_rat_overwrite,
    output logic [ARCH_REGS-1:0][PTAG_W-1:0]  o_rat_new_map,
    output logic                              o_busy,
    output logic [CNT_W-1:0]                  o_free_count
);

    localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned FL_IDX_W = $clog2(FL_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESTORE = 2'd1,
        S_REBUILD = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [FL_DEPTH-1:0][PTAG_W-1:0] r_entries;
    logic [FL_IDX_W-1:0]             r_head;
    logic [FL_IDX_W-1:0]             r_tail;
    logic [CNT_W-1:0]                r_count;
    logic [PTAG_W-1:0]               r_scan_idx;
    logic [PHYS_REGS-1:0]            r_used;
    logic [PHYS_REGS-1:0]            w_used;

    logic                            w_idle;
    logic                            w_rebuild_go;
    logic                            w_alloc;
    logic                            w_pop;
    logic                            w_cm_push;
    logic                            w_scan_push;
    logic                            w_push;
    logic [PTAG_W-1:0]               w_push_tag;

    // Tags referenced by the committed map are in use; everything else is free.
    always_comb begin
        w_used = '0;
        for (int unsigned a = 0; a < ARCH_REGS; a++) begin
            w_used[i_retire_map[a]] = 1'b1;
        end
    end

    // Rename/commit handshake and free-list push/pop selection.
    always_comb begin
        w_idle       = (r_state == S_IDLE);
        w_rebuild_go = (r_state == S_REBUILD) && !i_stall;
        w_alloc      = i_rn_valid && i_rn_has_dest && (i_rn_dest != '0);
        o_rn_ready   = !i_reset && w_idle && !i_stall && !i_flush &&
                       (!w_alloc || (r_count != '0));
        w_pop        = i_rn_valid && o_rn_ready && w_alloc;
        w_cm_push    = !i_reset && w_idle && !i_stall && !i_flush && i_cm_valid;
        w_scan_push  = w_rebuild_go && !r_used[r_scan_idx];
        w_push       = w_cm_push || w_scan_push;
        w_push_tag   = w_scan_push ? r_scan_idx : i_cm_free_tag;

        o_rn_new_tag      = r_entries[r_head];
        o_rat_reg_to_map  = i_rn_dest;
        o_rat_new_mapping = r_entries[r_head];
        o_rat_remap       = w_pop;
        o_rat_overwrite   = !i_reset && (r_state == S_RESTORE) && !i_stall;
        o_rat_new_map     = i_retire_map;
        o_busy            = !w_idle;
        o_free_count      = r_count;
    end

    // Recovery sequencing; a flush anywhere restarts from RESTORE.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_RESTORE;
        end else begin
            case (r_state)
                S_RESTORE: if (!i_stall) w_state_nxt = S_REBUILD;
                S_REBUILD: if (w_rebuild_go && (r_scan_idx == PTAG_W'(PHYS_REGS - 1)))
                               w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Free-list storage; a freed tag lands at the tail and is never bypassed to the head.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                r_entries[i] <= PTAG_W'(ARCH_REGS + i);
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= CNT_W'(FL_DEPTH);
            r_scan_idx <= '0;
            r_used     <= '0;
        end else if (i_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_scan_idx <= '0;
            r_used     <= w_used;
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= w_push_tag;
                r_tail            <= r_tail + FL_IDX_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + FL_IDX_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_rebuild_go) begin
                r_scan_idx <= r_scan_idx + PTAG_W'(1);
            end
        end
    end

    // Freeing an architectural-reset tag or pushing into a full list is illegal.
    a_cm_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        w_cm_push |-> ((i_cm_free_tag >= PTAG_W'(ARCH_REGS)) && (r_count < CNT_W'(FL_DEPTH))));

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Bench for rename_free_list_ctrl: directed rename/commit/flush vectors, with remap
// transactions checked by a scoreboard monitor and status checked inline.
module tb_rename_free_list_ctrl;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  stall;
    logic                  rn_valid;
    logic                  rn_has_dest;
    logic [4:0]            rn_dest;
    logic                  rn_ready;
    logic [5:0]            rn_new_tag;
    logic [4:0]            rat_reg_to_map;
    logic [5:0]            rat_new_mapping;
    logic                  rat_remap;
    logic                  cm_valid;
    logic [5:0]            cm_free_tag;
    logic                  flush;
    logic [31:0][5:0]      retire_map;
    logic                  rat_overwrite;
    logic [31:0][5:0]      rat_new_map;
    logic                  busy;
    logic [5:0]            free_count;

    typedef struct {
        int tag;
        int areg;
    } ren_t;

    ren_t q_exp[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rename_free_list_ctrl dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_stall           (stall),
        .i_rn_valid        (rn_valid),
        .i_rn_has_dest     (rn_has_dest),
        .i_rn_dest         (rn_dest),
        .o_rn_ready        (rn_ready),
        .o_rn_new_tag      (rn_new_tag),
        .o_rat_reg_to_map  (rat_reg_to_map),
        .o_rat_new_mapping (rat_new_mapping),
        .o_rat_remap       (rat_remap),
        .i_cm_valid        (cm_valid),
        .i_cm_free_tag     (cm_free_tag),
        .i_flush           (flush),
        .i_retire_map      (retire_map),
        .o_rat_overwrite   (rat_overwrite),
        .o_rat_new_map     (rat_new_map),
        .o_busy            (busy),
        .o_free_count      (free_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every remap pulse must match the oldest expected allocation.
    always @(negedge clk) begin
        if (!reset && rat_remap) begin
            total++;
            if (q_exp.size() == 0) begin
                bad++;
                $display("FAIL remap_unexpected actual_tag=%0d required=none", rat_new_mapping);
            end else begin
                ren_t e;
                e = q_exp.pop_front();
                if (int'(rat_new_mapping) != e.tag || int'(rat_reg_to_map) != e.areg ||
                    int'(rn_new_tag) != e.tag) begin
                    bad++;
                    $display("FAIL remap actual_tag=%0d actual_reg=%0d required_tag=%0d required_reg=%0d",
                             rat_new_mapping, rat_reg_to_map, e.tag, e.areg);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ren(input int d, input logic hd, input logic exp_rdy, input int exp_tag);
        rn_valid    = 1'b1;
        rn_has_dest = hd;
        rn_dest     = 5'(d);
        if (exp_rdy && hd && d != 0) q_exp.push_back('{tag: exp_tag, areg: d});
        @(negedge clk);
        chk("rn_ready", int'(rn_ready), int'(exp_rdy));
        cyc();
        rn_valid = 1'b0;
    endtask

    task automatic commit(input int tag);
        cm_valid    = 1'b1;
        cm_free_tag = 6'(tag);
        cyc();
        cm_valid = 1'b0;
    endtask

    // Flush now, then count busy and overwrite cycles after the flush edge.
    task automatic recovery(input int reflush_at, input int stall_at, input int stall_len,
                            output int busy_cyc, output int ow_cyc);
        int n;
        flush = 1'b1;
        rn_valid = 1'b1; rn_has_dest = 1'b1; rn_dest = 5'd9;
        @(negedge clk);
        chk("flush_rn_ready", int'(rn_ready), 0);
        cyc();
        flush = 1'b0; rn_valid = 1'b0;
        busy_cyc = 0; ow_cyc = 0; n = 0;
        while (n < 400) begin
            stall = (n >= stall_at) && (n < stall_at + stall_len);
            flush = (n == reflush_at);
            @(negedge clk);
            if (!busy) break;
            busy_cyc++;
            if (rat_overwrite) begin
                ow_cyc++;
                chk("rat_new_map", int'(rat_new_map == retire_map), 1);
            end
            if (n == 5) chk("recovery_rn_ready", int'(rn_ready), 0);
            if (n == reflush_at) begin busy_cyc = 0; ow_cyc = 0; end
            cyc();
            n++;
        end
        stall = 1'b0; flush = 1'b0;
        chk("recovery_bounded", int'(n < 400), 1);
    endtask

    int b, o;

    initial begin
        reset = 1'b1; stall = 1'b0; rn_valid = 1'b0; rn_has_dest = 1'b0; rn_dest = '0;
        cm_valid = 1'b0; cm_free_tag = '0; flush = 1'b0;
        for (int i = 0; i < 32; i++) retire_map[i] = 6'(i);
        rn_valid = 1'b1; rn_has_dest = 1'b1; rn_dest = 5'd5;
        cyc();
        @(negedge clk);
        chk("reset_rn_ready", int'(rn_ready), 0);
        cyc();
        reset = 1'b0; rn_valid = 1'b0;
        @(negedge clk);
        chk("reset_free_count", int'(free_count), 32);
        chk("reset_busy", int'(busy), 0);
        chk("reset_overwrite", int'(rat_overwrite), 0);
        chk("reset_head", int'(rn_new_tag), 32);
        cyc();

        // First allocation from reset contents.
        ren(5, 1'b1, 1'b1, 32);
        @(negedge clk);
        chk("count_after_first", int'(free_count), 31);
        chk("head_after_first", int'(rn_new_tag), 33);
        cyc();

        // Non-allocating requests.
        ren(0, 1'b1, 1'b1, 0);
        ren(7, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("count_no_alloc", int'(free_count), 31);
        cyc();

        // Drain to empty, then commit under a blocked rename.
        for (int i = 0; i < 31; i++) ren(1, 1'b1, 1'b1, 33 + i);
        @(negedge clk);
        chk("count_empty", int'(free_count), 0);
        cyc();
        cm_valid = 1'b1; cm_free_tag = 6'd40;
        ren(1, 1'b1, 1'b0, 0);
        cm_valid = 1'b0;
        @(negedge clk);
        chk("count_after_commit", int'(free_count), 1);
        chk("head_after_commit", int'(rn_new_tag), 40);
        cyc();
        ren(2, 1'b1, 1'b1, 40);

        // Same-cycle alloc + commit at count 10; freed tag goes to tail.
        for (int i = 0; i < 10; i++) commit(32 + i);
        @(negedge clk);
        chk("count_ten", int'(free_count), 10);
        cyc();
        cm_valid = 1'b1; cm_free_tag = 6'd50;
        ren(3, 1'b1, 1'b1, 32);
        cm_valid = 1'b0;
        @(negedge clk);
        chk("count_same_cycle", int'(free_count), 10);
        cyc();
        for (int i = 0; i < 9; i++) ren(3, 1'b1, 1'b1, 33 + i);
        @(negedge clk);
        chk("head_tail_tag", int'(rn_new_tag), 50);
        cyc();
        ren(4, 1'b1, 1'b1, 50);

        // Stall blocks rename and commit.
        commit(60);
        stall = 1'b1;
        ren(6, 1'b1, 1'b0, 0);
        commit(61);
        stall = 1'b0;
        @(negedge clk);
        chk("count_stall", int'(free_count), 1);
        cyc();
        ren(6, 1'b1, 1'b0 | 1'b1, 60);

        // Flush with identity retire map.
        for (int i = 0; i < 5; i++) commit(42 + i);
        for (int i = 0; i < 5; i++) ren(8, 1'b1, 1'b1, 42 + i);
        recovery(-1, -1, 0, b, o);
        chk("busy_cycles", b, 65);
        chk("overwrite_cycles", o, 1);
        @(negedge clk);
        chk("count_rebuilt", int'(free_count), 32);
        cyc();
        for (int i = 0; i < 3; i++) ren(10, 1'b1, 1'b1, 32 + i);

        // Even tags in use; reflush at scan idx 20, then stall 3 cycles in REBUILD.
        for (int i = 0; i < 32; i++) retire_map[i] = 6'(2 * i);
        recovery(21, 31, 3, b, o);
        chk("busy_cycles_stalled", b, 68);
        chk("overwrite_cycles_reflush", o, 1);
        @(negedge clk);
        chk("count_rebuilt_odd", int'(free_count), 32);
        cyc();
        for (int i = 0; i < 3; i++) ren(11, 1'b1, 1'b1, 2 * i + 1);

        // Reset during recovery.
        flush = 1'b1; cyc(); flush = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_count", int'(free_count), 32);
        chk("midreset_head", int'(rn_new_tag), 32);
        cyc();

        chk("scoreboard_drained", q_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
